// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch controller
// ST_TRAP exists only when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

    localparam int          FETCH_DATA_WIDTH   = 32;
    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_HOLD = 2'd2,
        ST_TRAP = 2'd3
`else
        ST_HOLD = 2'd2
`endif
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with load-target and increment-by-4 controls
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = FETCH_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(FETCH_RESET_VECTOR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic                  incr,
    output logic [DATA_WIDTH-1:0] pc
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    // Load wins over increment; the add wraps naturally at the bus width.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (incr) begin
            pc_d = pc_q + DATA_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch FSM with redirect and flush handling
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = FETCH_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(FETCH_RESET_VECTOR)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic                  misalign_trap
);

    fetch_state_e          state_q, state_d;
    logic                  flush_q, flush_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_WIDTH-1:0] pc;
    logic                  pc_load;
    logic                  pc_incr;
    logic                  redirect_live;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic                  trap_q, trap_d;
    logic                  target_misaligned;

    assign target_misaligned = (redirect_target[1:0] != 2'b00);
    assign redirect_live     = redirect && (state_q != ST_TRAP);
    assign misalign_trap     = trap_q;
`else
    logic                  unused_target_low;

    assign unused_target_low = ^redirect_target[1:0];
    assign redirect_live     = redirect;
    assign misalign_trap     = 1'b0;
`endif

    fetch_pc_reg #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val ({redirect_target[DATA_WIDTH-1:2], 2'b00}),
        .incr     (pc_incr),
        .pc       (pc)
    );

    always_comb begin
        state_d       = state_q;
        flush_d       = flush_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pc_load       = 1'b0;
        pc_incr       = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d        = trap_q;
`endif

        case (state_q)
            ST_REQ: begin
                // A grant taken together with a redirect fetches the stale PC; flush it on return.
                if (redirect_live) begin
                    state_d = imem_gnt ? ST_WAIT : ST_REQ;
                    flush_d = imem_gnt;
                end else if (imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_live) begin
                    state_d = imem_rvalid ? ST_REQ : ST_WAIT;
                    flush_d = !imem_rvalid;
                end else if (imem_rvalid) begin
                    if (flush_q) begin
                        flush_d = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc;
                        instr_valid_d = 1'b1;
                        pc_incr       = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_live) begin
                    state_d = ST_REQ;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_REQ;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
`endif
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (redirect_live) begin
            pc_load       = 1'b1;
            instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            // Trap is sticky; any in-flight response is dropped because TRAP ignores rvalid.
            if (target_misaligned) begin
                state_d    = ST_TRAP;
                trap_d     = 1'b1;
                flush_d    = 1'b0;
                instr_pc_d = redirect_target;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_REQ;
            flush_q       <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q        <= trap_d;
`endif
        end
    end

    assign imem_req    = (state_q == ST_REQ) && !rst;
    assign imem_addr   = pc;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        misalign_trap;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .misalign_trap   (misalign_trap)
    );

    // Memory contents as a scrambled function of address so stale data is recognisable.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'h0;
        instr_ready     = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Grant the current request, answer after dly idle cycles, leave the FSM in HOLD.
    task automatic fetch_one(input logic [31:0] data, input int dly);
        instr_ready = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt = 1'b0;
        repeat (dly) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || misalign_trap !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h trap=%b expected all zero", imem_req, instr_valid, instr, instr_pc, misalign_trap);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_release: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_basic_fetch();
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL wait_no_req: req=%b valid=%b expected 0 0", imem_req, instr_valid);
        end
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL basic_instr: valid=%b instr=%h pc=%h expected 1 00500093 00000000", instr_valid, instr, instr_pc);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL basic_next: valid=%b req=%b addr=%h expected 0 1 00000004", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_gnt_stall();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL gnt_stall[%0d]: req=%b addr=%h valid=%b expected 1 00000004 0", i, imem_req, imem_addr, instr_valid);
            end
        end
    endtask

    task automatic test_hold();
        fetch_one(32'h1234_5678, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || instr_pc !== 32'h4 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable[%0d]: valid=%b instr=%h pc=%h req=%b expected 1 12345678 00000004 0", i, instr_valid, instr, instr_pc, imem_req);
            end
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            failures++;
            $display("FAIL hold_release: req=%b addr=%h expected 1 00000008", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        logic seen_valid;
        seen_valid = 1'b0;
        imem_gnt   = 1'b1;
        tick();
        imem_gnt        = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect = 1'b0;
        seen_valid |= instr_valid;
        tick();
        seen_valid |= instr_valid;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        seen_valid |= instr_valid;
        checks++;
        if (seen_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL redirect_flush: seen_valid=%b req=%b addr=%h expected 0 1 00000100", seen_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        redirect        = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_redirect: req=%b addr=%h expected 1 fffffffc", imem_req, imem_addr);
        end
        fetch_one(32'hCAFE_F00D, 0);
        instr_ready = 1'b1;
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL wrap_instr: valid=%b pc=%h instr=%h expected 1 fffffffc cafef00d", instr_valid, instr_pc, instr);
        end
        tick();
        instr_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        redirect        = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst      = 1'b1;
        tick();
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: valid=%b req=%b addr=%h expected 0 1 00000000", instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_misalign();
        apply_reset();
        redirect        = 1'b1;
        redirect_target = 32'h102;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (misalign_trap !== 1'b1 || instr_pc !== 32'h102 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL misalign_trap[%0d]: trap=%b pc=%h req=%b valid=%b expected 1 00000102 0 0", i, misalign_trap, instr_pc, imem_req, instr_valid);
            end
            imem_gnt        = 1'b1;
            imem_rvalid     = 1'b1;
            redirect        = (i == 1);
            redirect_target = 32'h200;
            tick();
            idle_inputs();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (misalign_trap !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL misalign_reset: trap=%b req=%b addr=%h expected 0 1 00000000", misalign_trap, imem_req, imem_addr);
        end
`else
        checks++;
        if (misalign_trap !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL misalign_forced: trap=%b req=%b addr=%h expected 0 1 00000100", misalign_trap, imem_req, imem_addr);
        end
`endif
    endtask

    // Transaction-level model: delivered instructions must follow the expected PC
    // sequence (sequential +4, reset by each redirect) and carry that address's data.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] out_q[$];
        int          dly;
        int          delivered;
        logic        hold_pend, addr_pend, clear_pend;
        logic [31:0] h_instr, h_pc, a_prev;

        apply_reset();
        exp_pc     = 32'h0;
        dly        = 0;
        delivered  = 0;
        hold_pend  = 1'b0;
        addr_pend  = 1'b0;
        clear_pend = 1'b0;
        h_instr    = 32'h0;
        h_pc       = 32'h0;
        a_prev     = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (hold_pend && (instr_valid !== 1'b1 || instr !== h_instr || instr_pc !== h_pc)) begin
                failures++;
                $display("FAIL rnd_hold cyc=%0d: valid=%b instr=%h pc=%h expected 1 %h %h", cyc, instr_valid, instr, instr_pc, h_instr, h_pc);
            end
            if (addr_pend && (imem_req !== 1'b1 || imem_addr !== a_prev)) begin
                failures++;
                $display("FAIL rnd_req_stable cyc=%0d: req=%b addr=%h expected 1 %h", cyc, imem_req, imem_addr, a_prev);
            end
            if (clear_pend && instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL rnd_redirect_clear cyc=%0d: valid=%b expected 0", cyc, instr_valid);
            end
            if (imem_req === 1'b1 && out_q.size() != 0) begin
                failures++;
                $display("FAIL rnd_outstanding cyc=%0d: req=1 with %0d outstanding expected 0", cyc, out_q.size());
            end
            checks += int'(hold_pend) + int'(addr_pend) + int'(clear_pend);

            redirect        = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            redirect_target[1:0] = 2'b00;
`endif
            imem_gnt    = imem_req && ($urandom_range(0, 2) != 0);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (out_q.size() != 0) begin
                if (dly == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_data(out_q[0]);
                end else begin
                    dly--;
                end
            end
            instr_ready = ($urandom_range(0, 3) != 0);

            hold_pend  = instr_valid && !instr_ready && !redirect;
            addr_pend  = imem_req && !imem_gnt && !redirect;
            clear_pend = redirect;
            h_instr    = instr;
            h_pc       = instr_pc;
            a_prev     = imem_addr;
            if (imem_rvalid) void'(out_q.pop_front());
            if (imem_gnt) begin
                if (!redirect) begin
                    checks++;
                    if (imem_addr !== exp_pc) begin
                        failures++;
                        $display("FAIL rnd_req_addr cyc=%0d: addr=%h expected %h", cyc, imem_addr, exp_pc);
                    end
                end
                out_q.push_back(imem_addr);
                dly = $urandom_range(0, 2);
            end
            if (redirect) begin
                exp_pc = {redirect_target[31:2], 2'b00};
            end else if (instr_valid && instr_ready) begin
                checks++;
                delivered++;
                if (instr_pc !== exp_pc || instr !== mem_data(exp_pc)) begin
                    failures++;
                    $display("FAIL rnd_deliver cyc=%0d: pc=%h instr=%h expected %h %h", cyc, instr_pc, instr, exp_pc, mem_data(exp_pc));
                end
                exp_pc += 32'h4;
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (delivered < 100) begin
            failures++;
            $display("FAIL rnd_progress: delivered=%0d expected at least 100", delivered);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_gnt_stall();
        test_hold();
        test_redirect_wait();
        test_wrap();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
